// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one registered AND/OR/XOR/NAND unit between NUM_REQ requesters.
// Each accepted op runs IDLE -> EXEC -> RESP; the result is returned tagged with the requester index.
module logic_unit_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int ID_W    = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [2*NUM_REQ-1:0]       req_op,
    input  logic [WIDTH*NUM_REQ-1:0]   req_a,
    input  logic [WIDTH*NUM_REQ-1:0]   req_b,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [ID_W-1:0]            resp_id,
    output logic [WIDTH-1:0]           resp_data,
    output logic                       busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [ID_W:0]   REQ_CNT  = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_IDX = ID_W'(NUM_REQ - 1);

    logic [1:0]       state_q, state_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]  gnt_q, gnt_d;
    logic [ID_W-1:0]  resp_id_q, resp_id_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] resp_data_q, resp_data_d;

    logic [NUM_REQ-1:0][1:0]       op_arr;
    logic [NUM_REQ-1:0][WIDTH-1:0] a_arr, b_arr;

    generate
        for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
            assign op_arr[i] = req_op[2*i +: 2];
            assign a_arr[i]  = req_a[WIDTH*i +: WIDTH];
            assign b_arr[i]  = req_b[WIDTH*i +: WIDTH];
        end
    endgenerate

    // Scan starting at rr_ptr and wrapping; first pending requester wins.
    logic            any_valid;
    logic [ID_W-1:0] scan_idx;
    logic [ID_W:0]   cand;

    always_comb begin
        any_valid = 1'b0;
        scan_idx  = rr_ptr_q;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (cand >= REQ_CNT) cand = cand - REQ_CNT;
            if (!any_valid && req_valid[cand[ID_W-1:0]]) begin
                any_valid = 1'b1;
                scan_idx  = cand[ID_W-1:0];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        gnt_d       = gnt_q;
        resp_id_d   = resp_id_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        resp_data_d = resp_data_q;
        req_ready   = '0;
        case (state_q)
            S_IDLE: begin
                if (any_valid && !reset) begin
                    req_ready[scan_idx] = 1'b1;
                    gnt_d   = scan_idx;
                    op_d    = op_arr[scan_idx];
                    a_d     = a_arr[scan_idx];
                    b_d     = b_arr[scan_idx];
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (op_q)
                    2'b00:   resp_data_d = a_q & b_q;
                    2'b01:   resp_data_d = a_q | b_q;
                    2'b10:   resp_data_d = a_q ^ b_q;
                    default: resp_data_d = ~(a_q & b_q);
                endcase
                resp_id_d = gnt_q;
                state_d   = S_RESP;
            end
            S_RESP: begin
                if (resp_ready) begin
                    rr_ptr_d = (gnt_q == LAST_IDX) ? '0 : gnt_q + 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            gnt_q       <= '0;
            resp_id_q   <= '0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            resp_data_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt_q       <= gnt_d;
            resp_id_q   <= resp_id_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            resp_data_q <= resp_data_d;
        end
    end

    assign resp_valid = (state_q == S_RESP);
    assign resp_id    = resp_id_q;
    assign resp_data  = resp_data_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter: reset, single ops, backpressure,
// round-robin order, reset mid-flight and a request withdrawn before arbitration.
module tb_logic_unit_arbiter;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 8;
    localparam int ID_W    = 2;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [2*NUM_REQ-1:0]     req_op;
    logic [WIDTH*NUM_REQ-1:0] req_a;
    logic [WIDTH*NUM_REQ-1:0] req_b;
    logic                     resp_valid;
    logic                     resp_ready;
    logic [ID_W-1:0]          resp_id;
    logic [WIDTH-1:0]         resp_data;
    logic                     busy;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp4 [0:3];

    logic_unit_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_data(resp_data), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_slot(input int i, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        req_op[2*i +: 2] = op;
        req_a[8*i +: 8]  = a;
        req_b[8*i +: 8]  = b;
    endtask

    initial begin
        reset = 1'b1; req_valid = '0; req_op = '0; req_a = '0; req_b = '0; resp_ready = 1'b0;
        exp4[0] = 8'h03; exp4[1] = 8'h3F; exp4[2] = 8'h3C; exp4[3] = 8'hFC;

        // 1: reset for 3 cycles
        tick(); tick(); tick();
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_valid", 32'(resp_valid), 32'h0);
        chk("rst_busy",  32'(busy), 32'h0);
        chk("rst_data",  32'(resp_data), 32'h00);
        chk("rst_id",    32'(resp_id), 32'h0);
        reset = 1'b0;

        // 2: req0 AND, consumer always ready
        tick();
        set_slot(0, 2'b00, 8'hF0, 8'h3C);
        req_valid = 4'b0001; resp_ready = 1'b1;
        #1 chk("t2_ready", 32'(req_ready), 32'h1);
        tick(); req_valid = '0;
        chk("t2_exec_valid", 32'(resp_valid), 32'h0);
        chk("t2_exec_busy",  32'(busy), 32'h1);
        tick();
        chk("t2_valid", 32'(resp_valid), 32'h1);
        chk("t2_id",    32'(resp_id), 32'h0);
        chk("t2_data",  32'(resp_data), 32'h30);
        tick();
        chk("t2_done_valid", 32'(resp_valid), 32'h0);
        chk("t2_done_busy",  32'(busy), 32'h0);

        // 3: req1 XOR with consumer stalled 5 cycles, others pending meanwhile
        set_slot(1, 2'b10, 8'hAA, 8'hFF);
        req_valid = 4'b0010; resp_ready = 1'b0;
        #1 chk("t3_ready", 32'(req_ready), 32'h2);
        tick(); req_valid = 4'b1101;
        tick();
        for (int c = 0; c < 5; c++) begin
            chk("t3_hold_valid", 32'(resp_valid), 32'h1);
            chk("t3_hold_data",  32'(resp_data), 32'h55);
            chk("t3_hold_id",    32'(resp_id), 32'h1);
            chk("t3_hold_busy",  32'(busy), 32'h1);
            chk("t3_hold_ready", 32'(req_ready), 32'h0);
            if (c < 4) tick();
        end
        req_valid = '0; resp_ready = 1'b1;
        tick();
        chk("t3_done_valid", 32'(resp_valid), 32'h0);

        // 4: reset rr_ptr, then all valid continuously
        reset = 1'b1; tick(); reset = 1'b0;
        for (int i = 0; i < 4; i++) set_slot(i, 2'(i), 8'h0F, 8'h33);
        req_valid = 4'b1111; resp_ready = 1'b1;
        for (int g = 0; g < 5; g++) begin
            #1 chk("t4_grant", 32'(req_ready), 32'(1 << (g % 4)));
            tick();
            chk("t4_exec_ready", 32'(req_ready), 32'h0);
            tick();
            chk("t4_valid", 32'(resp_valid), 32'h1);
            chk("t4_id",    32'(resp_id), 32'(g % 4));
            chk("t4_data",  32'(resp_data), 32'(exp4[g % 4]));
            tick();
        end
        req_valid = '0;

        // 5: reset while req2 is in EXEC
        tick();
        req_valid = 4'b0100;
        #1 chk("t5_ready", 32'(req_ready), 32'h4);
        tick(); req_valid = '0; reset = 1'b1;
        #1 chk("t5_rst_ready", 32'(req_ready), 32'h0);
        tick(); reset = 1'b0;
        chk("t5_no_valid", 32'(resp_valid), 32'h0);
        chk("t5_no_busy",  32'(busy), 32'h0);
        req_valid = 4'b1111;
        #1 chk("t5_regrant", 32'(req_ready), 32'h1);
        tick(); req_valid = '0;
        tick(); tick();

        // 6: req3 pending during busy, withdrawn before IDLE, req1 raised (rr_ptr=1)
        req_valid = 4'b0100;
        #1 chk("t6_first", 32'(req_ready), 32'h4);
        tick(); req_valid = 4'b1000;
        chk("t6_exec_ready", 32'(req_ready), 32'h0);
        tick(); req_valid = 4'b0010;
        chk("t6_resp_id", 32'(resp_id), 32'h2);
        tick();
        chk("t6_grant1", 32'(req_ready), 32'h2);
        tick(); req_valid = '0;
        tick();
        chk("t6_data", 32'(resp_data), 32'h3F);
        chk("t6_id",   32'(resp_id), 32'h1);
        tick();
        req_valid = 4'b1111;
        #1 chk("t6_rr_ptr2", 32'(req_ready), 32'h4);
        tick(); req_valid = '0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
